// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package arb_pkg;

   localparam logic ARB_RR    = 1'b0;
   localparam logic ARB_FIXED = 1'b1;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   // Input must be one-hot (or zero); OR-ing the indices avoids a priority chain.
   function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: rotated double-width priority encode from start_ptr+1.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] start_ptr,
   input  logic [N-1:0]    excl,
   input  logic            mode,
   output logic [N-1:0]    win,
   output logic            found
);

   logic [N-1:0]    masked;
   logic [N-1:0]    rot;
   logic [N-1:0]    oh;
   logic [IDXW-1:0] shamt;
   logic [2*N-1:0]  dbl_req;
   logic [2*N-1:0]  dbl_win;

   always_comb begin
      masked = req & ~excl;
      if (mode == ARB_FIXED) begin
         shamt = '0;
      end else if (start_ptr == IDXW'(N - 1)) begin
         shamt = '0;
      end else begin
         shamt = start_ptr + 1'b1;
      end

      dbl_req = {masked, masked} >> shamt;
      rot     = dbl_req[N-1:0];

      oh    = '0;
      found = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
         if (rot[j] && !found) begin
            oh[j] = 1'b1;
            found = 1'b1;
         end
      end

      // Rotate the one-hot back into requester order.
      dbl_win = {oh, oh} << shamt;
      win     = dbl_win[2*N-1:N];
   end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way arbiter with registered one-hot grants, burst-hold limit, lock and RR/fixed modes.
module rr_arbiter_n
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 4,
   parameter int IDXW     = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            lock,
   input  logic            mode,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [IDXW-1:0] gnt_idx
);

   localparam int            HW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   state_t          state, state_n;
   logic [N-1:0]    gnt_n;
   logic [IDXW-1:0] idx_n;
   logic [IDXW-1:0] last_ptr, ptr_n;
   logic [HW-1:0]   hold_cnt, hold_n;
   logic [N-1:0]    win;
   logic            found;
   logic            cur_req;
   logic            take;

   // Excluding the current grantee is harmless unless it still requests,
   // which is exactly the forced-rotation case.
   rr_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .req       (req),
      .start_ptr (last_ptr),
      .excl      (gnt),
      .mode      (mode),
      .win       (win),
      .found     (found)
   );

   assign cur_req   = |(req & gnt);
   assign gnt_valid = |gnt;

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      idx_n   = gnt_idx;
      ptr_n   = last_ptr;
      hold_n  = hold_cnt;
      take    = 1'b0;

      case (state)
         IDLE: begin
            if (found) take = 1'b1;
         end
         GRANT: begin
            if (!cur_req) begin
               if (found) begin
                  take = 1'b1;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  hold_n  = '0;
               end
            end else if (lock || (MAX_HOLD == 0) || (hold_cnt < HOLD_MAX)) begin
               if (hold_cnt < HOLD_MAX) hold_n = hold_cnt + 1'b1;
            end else if (found) begin
               take = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase

      if (take) begin
         state_n = GRANT;
         gnt_n   = win;
         idx_n   = IDXW'(onehot_to_idx(32'(win)));
         ptr_n   = idx_n;
         hold_n  = HW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_idx  <= '0;
         hold_cnt <= '0;
         last_ptr <= IDXW'(N - 1);
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         gnt_idx  <= idx_n;
         hold_cnt <= hold_n;
         last_ptr <= ptr_n;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n (N=4, MAX_HOLD=4 plus an unlimited-hold instance).
module tb_rr_arbiter_n;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, req0;
   logic       lock, mode;
   logic [3:0] gnt, gnt0;
   logic       gnt_valid, gnt_valid0;
   logic [1:0] gnt_idx, gnt_idx0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .mode      (mode),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   rr_arbiter_n #(.N(4), .MAX_HOLD(0)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req0),
      .lock      (lock),
      .mode      (mode),
      .gnt       (gnt0),
      .gnt_valid (gnt_valid0),
      .gnt_idx   (gnt_idx0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic v, input logic [1:0] i);
      chk({tag, ".gnt"}, 32'(gnt), 32'(g));
      chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
      chk({tag, ".idx"}, 32'(gnt_idx), 32'(i));
   endtask

   initial begin
      logic [3:0] prev_req;
      logic [3:0] nreq;
      int unsigned waits [4];
      int unsigned wmax;

      rst_n = 1'b0;
      req   = '0;
      req0  = '0;
      lock  = 1'b0;
      mode  = 1'b0;
      #12;
      chk_all("reset", 4'b0000, 1'b0, 2'd0);
      chk("reset.gnt0", 32'(gnt0), 32'd0);
      tick();
      rst_n = 1'b1;

      // Full rotation with all four requesting
      req = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            chk_all($sformatf("rr_all.r%0d.c%0d", r, c), 4'(1 << r), 1'b1, 2'(r));
         end
      end
      tick();
      chk_all("rr_wrap", 4'b0001, 1'b1, 2'd0);

      // Grantee drop re-arbitrates with no bubble
      req = 4'b0010;
      tick();
      chk_all("drop_to_1", 4'b0010, 1'b1, 2'd1);
      req = 4'b1100;
      tick();
      chk_all("drop_to_2", 4'b0100, 1'b1, 2'd2);
      req = 4'b0000;
      tick();
      chk_all("idle_hold_idx", 4'b0000, 1'b0, 2'd2);

      // Lock beyond MAX_HOLD, then release forces rotation
      req = 4'b0010;
      tick();
      chk_all("lock_pre", 4'b0010, 1'b1, 2'd1);
      req  = 4'b1010;
      lock = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("lock.c%0d", c), 32'(gnt), 32'h2);
      end
      lock = 1'b0;
      tick();
      chk_all("lock_release", 4'b1000, 1'b1, 2'd3);

      // Fixed priority sequence
      req = 4'b0000;
      tick();
      chk("fp_idle", 32'(gnt), 32'h0);
      mode = 1'b1;
      req  = 4'b1110;
      tick();
      chk_all("fp_1", 4'b0010, 1'b1, 2'd1);
      req = 4'b1100;
      tick();
      chk_all("fp_2", 4'b0100, 1'b1, 2'd2);
      req = 4'b1000;
      tick();
      chk_all("fp_3", 4'b1000, 1'b1, 2'd3);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("fp_alone.c%0d", c), 32'(gnt), 32'h8);
      end

      // Asynchronous reset mid-grant
      mode = 1'b0;
      req  = 4'b0100;
      tick();
      chk_all("pre_reset", 4'b0100, 1'b1, 2'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 4'b0000, 1'b0, 2'd0);
      req = 4'b1000;
      #2;
      rst_n = 1'b1;
      tick();
      chk_all("post_reset", 4'b1000, 1'b1, 2'd3);

      // Unlimited hold instance
      req0 = 4'b0011;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk($sformatf("nolimit.c%0d", c), 32'(gnt0), 32'h1);
      end
      req0 = 4'b0010;
      tick();
      chk("nolimit_drop", 32'(gnt0), 32'h2);
      chk("nolimit_idx", 32'(gnt_idx0), 32'd1);

      // Random sticky requests, RR, no lock: safety and starvation bound
      req = 4'b0000;
      tick();
      for (int i = 0; i < 4; i++) waits[i] = 0;
      prev_req = req;
      for (int c = 0; c < 10000; c++) begin
         nreq = '0;
         for (int i = 0; i < 4; i++) begin
            if (prev_req[i]) nreq[i] = !(gnt[i] && ($urandom_range(0, 3) == 0));
            else             nreq[i] = ($urandom_range(0, 3) == 0);
         end
         req = nreq;
         prev_req = nreq;
         tick();
         chk("rnd.onehot0", 32'($onehot0(gnt)), 32'd1);
         chk("rnd.no_unreq", 32'(gnt & ~prev_req), 32'd0);
         if (gnt_valid) chk("rnd.idx", 32'(gnt_idx), 32'(arb_pkg::onehot_to_idx(32'(gnt))));
         wmax = 0;
         for (int i = 0; i < 4; i++) begin
            if (prev_req[i] && !gnt[i]) waits[i] = waits[i] + 1;
            else                        waits[i] = 0;
            if (waits[i] > wmax) wmax = waits[i];
         end
         chk("rnd.starve", 32'(wmax <= 12), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
